// File: rtl/timer_pkg.sv
// timer_pkg: state encoding and BCD digit limits shared by the countdown timer.
package timer_pkg;
  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] LO_MAX = 4'd9;
  localparam logic [DIG_W-1:0] HI_MAX = 4'd5;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;
endpackage

// File: rtl/countdown_timer_digit.sv
// bcd_down_digit: one BCD digit that decrements on borrow, wrapping 0 -> MAX.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [DIG_W-1:0] MAX = LO_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             borrow_in,
  input  logic             load,
  input  logic [DIG_W-1:0] load_val,
  output logic [DIG_W-1:0] digit,
  output logic             borrow_out
);
  logic [DIG_W-1:0] digit_q, digit_d;
  assign borrow_out = borrow_in && digit_q == '0;
  assign digit_d = load ? load_val
                 : (en && borrow_in) ? (digit_q == '0 ? MAX : digit_q - 1'b1)
                 : digit_q;
  assign digit = digit_q;
  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else digit_q <= digit_d;
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD hh:mm:ss countdown with preset load and expiry pulse.
// Define AUTO_RELOAD_EN to reload the stored preset on expiry (periodic mode).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_PER_SEC = 100_000_000,
  parameter int HR_MAX      = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             start_stop,
  input  logic [DIG_W-1:0] preset_hr_h,
  input  logic [DIG_W-1:0] preset_hr_l,
  input  logic [DIG_W-1:0] preset_min_h,
  input  logic [DIG_W-1:0] preset_min_l,
  input  logic [DIG_W-1:0] preset_sec_h,
  input  logic [DIG_W-1:0] preset_sec_l,
  output logic [DIG_W-1:0] hr_h,
  output logic [DIG_W-1:0] hr_l,
  output logic [DIG_W-1:0] min_h,
  output logic [DIG_W-1:0] min_l,
  output logic [DIG_W-1:0] sec_h,
  output logic [DIG_W-1:0] sec_l,
  output logic             running,
  output logic             done,
  output logic             load_err
);
  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);
  state_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6*DIG_W-1:0] preset_in, cur, load_val;
  logic done_q, done_d, err_q, err_d, dig_load, dec, tick, valid, ld_ok, is_one;
  logic [6:0] b;
  logic [7:0] hr_val;
  assign preset_in = {preset_hr_h, preset_hr_l, preset_min_h, preset_min_l, preset_sec_h, preset_sec_l};
  assign hr_val = 8'(preset_hr_h) * 8'd10 + 8'(preset_hr_l);
  assign valid = preset_sec_l <= LO_MAX && preset_min_l <= LO_MAX && preset_hr_l <= LO_MAX &&
                 preset_sec_h <= HI_MAX && preset_min_h <= HI_MAX && hr_val <= 8'(HR_MAX);
  assign ld_ok = !clear && load && state_q != RUN && valid;
  assign tick = state_q == RUN && pre_q == PRE_LAST;
  assign is_one = cur == 24'd1;
  // The borrow chain is always fed at sec_l, so the final borrow flags an all-zero value.
  assign b[0] = 1'b1;
  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_down_digit #(.MAX((i == 1 || i == 3) ? HI_MAX : LO_MAX)) u_dig (
      .clk       (clk),
      .rst       (rst),
      .en        (dec),
      .borrow_in (b[i]),
      .load      (dig_load),
      .load_val  (load_val[i*DIG_W +: DIG_W]),
      .digit     (cur[i*DIG_W +: DIG_W]),
      .borrow_out(b[i+1])
    );
  end
  assign {hr_h, hr_l, min_h, min_l, sec_h, sec_l} = cur;
  assign running = state_q == RUN;
  assign done = done_q;
  assign load_err = err_q;
`ifdef AUTO_RELOAD_EN
  logic [6*DIG_W-1:0] preset_q;
  always_ff @(posedge clk) begin
    if (rst) preset_q <= '0;
    else if (ld_ok) preset_q <= preset_in;
  end
`endif
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    load_val = preset_in;
    dig_load = 1'b0;
    dec = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      pre_d = '0;
      dig_load = 1'b1;
      load_val = '0;
    end else if (load && state_q != RUN) begin
      if (ld_ok) begin
        state_d = IDLE;
        pre_d = '0;
        dig_load = 1'b1;
      end else err_d = 1'b1;
    end else if (tick && is_one) begin
      done_d = 1'b1;
      pre_d = '0;
`ifdef AUTO_RELOAD_EN
      dig_load = 1'b1;
      load_val = preset_q;
`else
      dec = 1'b1;
      state_d = EXPIRED;
`endif
    end else if (start_stop) begin
      state_d = state_q == IDLE ? (b[6] ? IDLE : RUN)
              : state_q == RUN ? PAUSE
              : state_q == PAUSE ? RUN : state_q;
    end else if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      dec = tick;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench; expected tick events are queued at start and matched by a monitor.
module tb_countdown_timer;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, load = 1'b0, start_stop = 1'b0;
  logic [23:0] pre = '0;
  logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
  logic running, done, load_err;
  logic [23:0] cur, prev_cur = '0;
  typedef struct {int c; logic [23:0] v; logic d;} exp_t;
  exp_t sb[$];
  int pass_cnt = 0, total = 0, cyc_cnt = 0;
  bit mon_en = 1'b0;
  assign cur = {hr_h, hr_l, min_h, min_l, sec_h, sec_l};

  countdown_timer #(.CLK_PER_SEC(4), .HR_MAX(23)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .start_stop(start_stop),
    .preset_hr_h(pre[23:20]), .preset_hr_l(pre[19:16]), .preset_min_h(pre[15:12]),
    .preset_min_l(pre[11:8]), .preset_sec_h(pre[7:4]), .preset_sec_l(pre[3:0]),
    .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l), .sec_h(sec_h), .sec_l(sec_l),
    .running(running), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Any digit change or done pulse while monitoring must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en && (cur !== prev_cur || done)) begin
      total++;
      if (sb.size() == 0) $display("FAIL unexpected_event cycle=%0d got %h done=%b want none", cyc_cnt, cur, done);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (cur !== e.v || done !== e.d || cyc_cnt != e.c)
          $display("FAIL tick_event got cycle=%0d %h done=%b want cycle=%0d %h done=%b", cyc_cnt, cur, done, e.c, e.v, e.d);
        else pass_cnt++;
      end
    end
    prev_cur = cur;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] p);
    pre = p;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    mon_en = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  function automatic void push(input int c, input logic [23:0] v, input logic d);
    sb.push_back('{c: c, v: v, d: d});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc(10);
    rst = 1'b0;
    cyc(1);
    total++; if (cur !== 24'h0) $display("FAIL reset_digits got %h want %h", cur, 24'h0); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (load_err !== 1'b0) $display("FAIL reset_load_err got %b want 0", load_err); else pass_cnt++;
  endtask

  task automatic test_basic();
    int s;
    do_load(24'h000003);
    total++; if (cur !== 24'h000003) $display("FAIL basic_load got %h want %h", cur, 24'h000003); else pass_cnt++;
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    total++; if (running !== 1'b1) $display("FAIL basic_running got %b want 1", running); else pass_cnt++;
    push(s + 4, 24'h000002, 1'b0);
    push(s + 8, 24'h000001, 1'b0);
    push(s + 12, 24'h000000, 1'b1);
    cyc(14);
    total++; if (sb.size() != 0) $display("FAIL basic_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL basic_expired_running got %b want 0", running); else pass_cnt++;
    sb.delete();
    mon_en = 1'b0;
  endtask

  task automatic test_borrow();
    int s;
    do_load(24'h010000);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h005959, 1'b0);
    cyc(6);
    total++; if (sb.size() != 0) $display("FAIL borrow_min_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    sb.delete();
    pulse_clear();
    do_load(24'h100000);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h095959, 1'b0);
    cyc(6);
    total++; if (sb.size() != 0) $display("FAIL borrow_hr_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    sb.delete();
    pulse_clear();
  endtask

  task automatic test_pause();
    int s;
    do_load(24'h000005);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h000004, 1'b0);
    cyc(6);
    pulse_ss();
    total++; if (running !== 1'b0) $display("FAIL pause_running got %b want 0", running); else pass_cnt++;
    cyc(20);
    total++; if (cur !== 24'h000004) $display("FAIL pause_hold got %h want %h", cur, 24'h000004); else pass_cnt++;
    pulse_ss();
    s = cyc_cnt;
    push(s + 2, 24'h000003, 1'b0);
    total++; if (running !== 1'b1) $display("FAIL resume_running got %b want 1", running); else pass_cnt++;
    cyc(3);
    total++; if (sb.size() != 0) $display("FAIL pause_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    sb.delete();
    pulse_clear();
  endtask

  task automatic test_clear_ignored();
    int dn = 0;
    do_load(24'h000010);
    pulse_ss();
    cyc(1);
    do_load(24'h000005);
    total++; if (cur !== 24'h000010) $display("FAIL run_load_ignored got %h want %h", cur, 24'h000010); else pass_cnt++;
    total++; if (running !== 1'b1) $display("FAIL run_load_running got %b want 1", running); else pass_cnt++;
    total++; if (load_err !== 1'b0) $display("FAIL run_load_err got %b want 0", load_err); else pass_cnt++;
    pulse_clear();
    total++; if (cur !== 24'h0) $display("FAIL clear_digits got %h want %h", cur, 24'h0); else pass_cnt++;
    total++; if (running !== 1'b0) $display("FAIL clear_running got %b want 0", running); else pass_cnt++;
    if (done) dn++;
    repeat (8) begin
      cyc(1);
      if (done) dn++;
    end
    total++; if (dn != 0) $display("FAIL clear_no_done got %0d pulses want 0", dn); else pass_cnt++;
    pulse_ss();
    cyc(2);
    total++; if (running !== 1'b0) $display("FAIL zero_start_ignored got %b want 0", running); else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [23:0] bad [5] = '{24'h00123A, 24'h000060, 24'h240000, 24'h006000, 24'h0A0000};
    do_load(24'h001234);
    total++; if (cur !== 24'h001234) $display("FAIL valid_load got %h want %h", cur, 24'h001234); else pass_cnt++;
    foreach (bad[k]) begin
      do_load(bad[k]);
      total++; if (load_err !== 1'b1) $display("FAIL bad_load_err %h got %b want 1", bad[k], load_err); else pass_cnt++;
      total++; if (cur !== 24'h001234) $display("FAIL bad_load_digits %h got %h want %h", bad[k], cur, 24'h001234); else pass_cnt++;
      cyc(1);
      total++; if (load_err !== 1'b0) $display("FAIL bad_load_pulse %h got %b want 0", bad[k], load_err); else pass_cnt++;
    end
    do_load(24'h235959);
    total++; if (cur !== 24'h235959) $display("FAIL max_load got %h want %h", cur, 24'h235959); else pass_cnt++;
    total++; if (load_err !== 1'b0) $display("FAIL max_load_err got %b want 0", load_err); else pass_cnt++;
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    int s;
    do_load(24'h000002);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h000001, 1'b0);
    push(s + 8, 24'h000002, 1'b1);
    push(s + 12, 24'h000001, 1'b0);
    push(s + 16, 24'h000002, 1'b1);
    cyc(18);
    total++; if (sb.size() != 0) $display("FAIL reload_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    total++; if (running !== 1'b1) $display("FAIL reload_running got %b want 1", running); else pass_cnt++;
    sb.delete();
    pulse_clear();
  endtask
`else
  task automatic test_expiry();
    int s;
    do_load(24'h000002);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h000001, 1'b0);
    push(s + 8, 24'h000000, 1'b1);
    cyc(10);
    total++; if (sb.size() != 0) $display("FAIL expiry_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    pulse_ss();
    total++; if (running !== 1'b0) $display("FAIL expired_start_ignored got %b want 0", running); else pass_cnt++;
    sb.delete();
    mon_en = 1'b0;
    do_load(24'h000001);
    pulse_ss();
    s = cyc_cnt;
    mon_en = 1'b1;
    push(s + 4, 24'h000000, 1'b1);
    cyc(3);
    pulse_ss();
    total++; if (running !== 1'b0) $display("FAIL expiry_beats_ss got %b want 0", running); else pass_cnt++;
    cyc(4);
    total++; if (running !== 1'b0) $display("FAIL expiry_stays got %b want 0", running); else pass_cnt++;
    total++; if (sb.size() != 0) $display("FAIL expiry_ss_drain got %0d pending want 0", sb.size()); else pass_cnt++;
    sb.delete();
    mon_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clear_ignored();
    test_invalid();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_expiry();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
